arbitro_salida: RTL and testbench
=================================

Name: arbitro_salida

Overview:
- Egress-side drain arbiter for the four output FIFOs (4..7) that the ingress arbiter fills.
- Pops one word at a time from a non-empty output FIFO, chosen round-robin, and registers it.
- Presents the word on a single serial egress port with a valid/full back-pressure handshake.
- Keeps a per-channel count of delivered words.

Parameters:
- DATA_W, 6, width of one FIFO word; passed through unmodified.
- CNT_W, 8, width of each per-channel delivered-word counter; the counter wraps.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- empty4, empty5, empty6, empty7  input  1 each  output-FIFO empty flags.
- data4, data5, data6, data7  input  DATA_W each  FIFO read data; valid the cycle after pop.
- full_out  input  1  downstream cannot accept; holds the egress word.
- pop4, pop5, pop6, pop7  output  1 each  one-cycle FIFO read strobes; at most one high.
- data_out  output  DATA_W  registered egress word.
- valid_out  output  1  data_out is valid.
- sel  output  2  index of the channel being served (0 = FIFO4 .. 3 = FIFO7).
- cnt4, cnt5, cnt6, cnt7  output  CNT_W each  words delivered per channel.
- idle  output  1  FSM is in IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - All pop* = 0; valid_out = 0; data_out = 0; sel = 0.
  - All cnt* = 0; idle = 1.
  - Round-robin last-grant pointer = 3, so the first grant goes to channel 0.
- States (one-hot, 4 bits): IDLE, POP, CAPT, SEND.
- IDLE:
  - If any empty* = 0 and full_out = 0: grant the first non-empty channel searching last+1, last+2, ... modulo 4.
  - Register the granted index into sel, then go to POP.
  - Otherwise stay in IDLE.
- POP (exactly 1 cycle):
  - pop[sel] = 1; every other pop = 0. pop* is decoded combinationally from state and sel.
  - Always goes to CAPT.
- CAPT (1 cycle): data_out <= data[sel] (FIFO read latency is 1); then go to SEND.
- SEND:
  - valid_out = 1.
  - If full_out = 0 this cycle: cnt[sel] += 1 (wraps at 2^CNT_W), last <= sel, go to IDLE.
  - If full_out = 1: hold SEND with data_out and valid_out stable; no counter change.
- Latency: IDLE grant to first valid_out is 3 cycles (POP, CAPT, SEND). Minimum period per word is 4 cycles.
- full_out in POP or CAPT: ignored; the word already popped is never dropped.
- Empty flag changes after the grant are ignored until the next IDLE decision.
- A pop is never issued to a FIFO flagged empty in the grant cycle.
- All four FIFOs non-empty: grant order is 0,1,2,3,0,... No channel is served twice while another is pending.
- reset = 1 in any state: next state is IDLE, all outputs take their reset values.
  - An in-flight word is discarded and not counted.
- Illegal state encoding: go to IDLE with reset-value outputs.
- idle = 1 only in IDLE; valid_out = 1 only in SEND.

Decomposition:
- Shared package arbitro_pkg:
  - State encodings IDLE = 4'b0001, POP = 4'b0010, CAPT = 4'b0100, SEND = 4'b1000.
  - Default DATA_W.
  - Channel index constants CH4 = 2'd0 .. CH7 = 2'd3.
- Sub-module rr_grant (combinational):
  - Inputs: request vector (~empty*) and last pointer.
  - Outputs: grant index and any_req.
  - Reusable by the ingress arbiter later.

Test Plan:
- Reset: hold reset 2 cycles with FIFO4 non-empty -> pop* = 0, valid_out = 0, cnt* = 0, idle = 1 throughout; first grant after release is sel = 0.
- Single word: only empty5 = 0, data5 = 6'h2A -> pop5 at cycle 1, valid_out at cycle 3 with data_out = 6'h2A; cnt5 = 1; idle at cycle 4.
- Fairness: all FIFOs hold 2 words -> sel sequence 0,1,2,3,0,1,2,3; each cnt = 2 after 32 cycles.
- Back-pressure: full_out = 1 for 5 cycles during SEND -> valid_out and data_out held for 6 cycles; cnt increments once on release. full_out = 1 in IDLE -> no pop.
- Reset mid-operation: assert reset in CAPT -> next cycle IDLE, valid_out = 0, counters unchanged.
- Counter wrap: CNT_W = 2, 5 words on FIFO7 -> cnt7 reads 1 after the 5th word.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared definitions for the egress drain arbiter: FSM encodings, channel
// indices and the default FIFO word width.
package arbitro_pkg;

    localparam int DATA_W_DEF = 6;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        POP  = 4'b0010,
        CAPT = 4'b0100,
        SEND = 4'b1000
    } state_t;

    localparam logic [1:0] CH4 = 2'd0;
    localparam logic [1:0] CH5 = 2'd1;
    localparam logic [1:0] CH6 = 2'd2;
    localparam logic [1:0] CH7 = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Four-way round-robin picker: first requester after the last-served index,
// wrapping modulo 4. Purely combinational.
module rr_grant (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any_req
);

    // Scan last+1 .. last+4 and keep the first hit
    always_comb begin
        logic       found;
        logic       hit;
        logic [1:0] idx;
        grant = last;
        found = 1'b0;
        hit   = 1'b0;
        idx   = last;
        for (int k = 1; k <= 4; k++) begin
            idx   = last + 2'(k);
            hit   = req[idx] & ~found;
            grant = hit ? idx : grant;
            found = found | req[idx];
        end
        any_req = |req;
    end

endmodule

// File: rtl/arbitro_salida.sv
// Egress drain arbiter: pops one word at a time from a non-empty output FIFO
// in round-robin order and presents it on a valid/full egress port.
module arbitro_salida
    import arbitro_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty4,
    input  logic              empty5,
    input  logic              empty6,
    input  logic              empty7,
    input  logic [DATA_W-1:0] data4,
    input  logic [DATA_W-1:0] data5,
    input  logic [DATA_W-1:0] data6,
    input  logic [DATA_W-1:0] data7,
    input  logic              full_out,
    output logic              pop4,
    output logic              pop5,
    output logic              pop6,
    output logic              pop7,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        sel,
    output logic [CNT_W-1:0]  cnt4,
    output logic [CNT_W-1:0]  cnt5,
    output logic [CNT_W-1:0]  cnt6,
    output logic [CNT_W-1:0]  cnt7,
    output logic              idle
);

    state_t            state_r;
    logic [1:0]        last_r;
    logic [CNT_W-1:0]  cnt_r [4];
    logic [3:0]        req_s;
    logic [1:0]        grant_s;
    logic              any_req_s;
    logic [3:0]        pop_s;
    logic [DATA_W-1:0] data_mux_s;

    assign req_s = ~{empty7, empty6, empty5, empty4};

    rr_grant u_rr_grant (
        .req     (req_s),
        .last    (last_r),
        .grant   (grant_s),
        .any_req (any_req_s)
    );

    // Read strobe decode: only the served FIFO, only in POP
    always_comb begin
        pop_s = 4'b0000;
        if (state_r == POP) begin
            pop_s = onehot4(sel);
        end else begin
            pop_s = 4'b0000;
        end
    end

    assign {pop7, pop6, pop5, pop4} = pop_s;

    // Read-data mux for the served channel
    always_comb begin
        data_mux_s = data4;
        case (sel)
            CH4:     data_mux_s = data4;
            CH5:     data_mux_s = data5;
            CH6:     data_mux_s = data6;
            CH7:     data_mux_s = data7;
            default: data_mux_s = data4;
        endcase
    end

    assign cnt4 = cnt_r[0];
    assign cnt5 = cnt_r[1];
    assign cnt6 = cnt_r[2];
    assign cnt7 = cnt_r[3];

    // Drain FSM with registered egress outputs and delivery counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            sel       <= CH4;
            last_r    <= CH7;
            data_out  <= '0;
            valid_out <= 1'b0;
            idle      <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s && !full_out) begin
                        sel     <= grant_s;
                        idle    <= 1'b0;
                        state_r <= POP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                POP: begin
                    state_r <= CAPT;
                end
                CAPT: begin
                    // FIFO data is valid one cycle after the pop strobe
                    data_out  <= data_mux_s;
                    valid_out <= 1'b1;
                    state_r   <= SEND;
                end
                SEND: begin
                    if (!full_out) begin
                        cnt_r[sel] <= cnt_r[sel] + CNT_W'(1);
                        last_r     <= sel;
                        valid_out  <= 1'b0;
                        idle       <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= SEND;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    sel       <= CH4;
                    last_r    <= CH7;
                    data_out  <= '0;
                    valid_out <= 1'b0;
                    idle      <= 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        cnt_r[i] <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_salida.sv
// Self-checking bench for arbitro_salida: FIFO models, a round-robin order
// reference built from queue contents, and directed plus randomized scenarios.
module tb_arbitro_salida;

    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic [1:0]        ch;
        logic [DATA_W-1:0] d;
    } word_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        empty_v;
    logic [DATA_W-1:0] rd_v [4];
    logic              full_out;
    logic              pop4, pop5, pop6, pop7;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [1:0]        sel;
    logic [CNT_W-1:0]  cnt4, cnt5, cnt6, cnt7;
    logic              idle;
    logic [3:0]        pop_v;
    logic [CNT_W-1:0]  cnt_v [4];

    logic              reset_b;
    logic              empty7_b;
    logic [DATA_W-1:0] data7_b;
    logic              pop4_b, pop5_b, pop6_b, pop7_b;
    logic [DATA_W-1:0] data_out_b;
    logic              valid_out_b;
    logic [1:0]        sel_b;
    logic [1:0]        cnt4_b, cnt5_b, cnt6_b, cnt7_b;
    logic              idle_b;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] mem [4][16];
    int                head [4];
    int                tail [4];
    logic [CNT_W-1:0]  cnt_model [4];
    word_t             exp_q [$];

    always #5 clk = ~clk;

    assign pop_v = {pop7, pop6, pop5, pop4};
    assign cnt_v[0] = cnt4;
    assign cnt_v[1] = cnt5;
    assign cnt_v[2] = cnt6;
    assign cnt_v[3] = cnt7;

    arbitro_salida #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .empty4(empty_v[0]), .empty5(empty_v[1]), .empty6(empty_v[2]), .empty7(empty_v[3]),
        .data4(rd_v[0]), .data5(rd_v[1]), .data6(rd_v[2]), .data7(rd_v[3]),
        .full_out(full_out),
        .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
        .data_out(data_out), .valid_out(valid_out), .sel(sel),
        .cnt4(cnt4), .cnt5(cnt5), .cnt6(cnt6), .cnt7(cnt7), .idle(idle)
    );

    arbitro_salida #(.DATA_W(DATA_W), .CNT_W(2)) u_wrap (
        .clk(clk), .reset(reset_b),
        .empty4(1'b1), .empty5(1'b1), .empty6(1'b1), .empty7(empty7_b),
        .data4(6'h00), .data5(6'h00), .data6(6'h00), .data7(data7_b),
        .full_out(1'b0),
        .pop4(pop4_b), .pop5(pop5_b), .pop6(pop6_b), .pop7(pop7_b),
        .data_out(data_out_b), .valid_out(valid_out_b), .sel(sel_b),
        .cnt4(cnt4_b), .cnt5(cnt5_b), .cnt6(cnt6_b), .cnt7(cnt7_b), .idle(idle_b)
    );

    task automatic clear_fifos();
        for (int c = 0; c < 4; c++) begin
            head[c] = 0;
            tail[c] = 0;
            rd_v[c] = '0;
            cnt_model[c] = '0;
        end
        empty_v = 4'hF;
        exp_q.delete();
    endtask

    task automatic load(input int ch, input logic [DATA_W-1:0] d);
        mem[ch][tail[ch]] = d;
        tail[ch]++;
        empty_v[ch] = 1'b0;
    endtask

    // Reference order: repeatedly serve the first non-empty queue after the last one served
    task automatic build_expected();
        int    n [4];
        int    off [4];
        int    last;
        int    total;
        word_t w;
        exp_q.delete();
        total = 0;
        last  = 3;
        for (int c = 0; c < 4; c++) begin
            n[c] = tail[c] - head[c];
            off[c] = head[c];
            total += n[c];
        end
        while (total > 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (last + k) % 4;
                if (n[c] > 0) begin
                    w.ch = 2'(c);
                    w.d  = mem[c][off[c]];
                    exp_q.push_back(w);
                    off[c]++;
                    n[c]--;
                    total--;
                    last = c;
                    break;
                end
            end
        end
    endtask

    task automatic step();
        logic [3:0]        p;
        logic              hold;
        logic [DATA_W-1:0] held;
        logic              rst_edge;
        p = pop_v;
        vectors++;
        if ((p & (p - 4'd1)) != 4'd0 || (p & empty_v) != 4'd0) begin
            miscompares++;
            $display("FAIL pop_legal: pop=%b empty=%b, need at most one pop to a non-empty FIFO", p, empty_v);
        end
        if (valid_out && !full_out && !reset) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL extra_word: got sel=%0d data=%h, expected no delivery", sel, data_out);
            end else begin
                if (sel !== exp_q[0].ch || data_out !== exp_q[0].d) begin
                    miscompares++;
                    $display("FAIL delivery: got sel=%0d data=%h, expected sel=%0d data=%h",
                             sel, data_out, exp_q[0].ch, exp_q[0].d);
                end
                cnt_model[exp_q[0].ch] = cnt_model[exp_q[0].ch] + CNT_W'(1);
                void'(exp_q.pop_front());
            end
        end
        hold     = valid_out && full_out && !reset;
        held     = data_out;
        rst_edge = reset;
        @(posedge clk);
        #1;
        if (rst_edge) begin
            for (int c = 0; c < 4; c++) cnt_model[c] = '0;
            exp_q.delete();
        end
        for (int c = 0; c < 4; c++) begin
            if (p[c]) begin
                rd_v[c] = mem[c][head[c]];
                head[c]++;
                empty_v[c] = (head[c] == tail[c]);
            end
        end
        vectors++;
        if (cnt_v[0] !== cnt_model[0] || cnt_v[1] !== cnt_model[1] ||
            cnt_v[2] !== cnt_model[2] || cnt_v[3] !== cnt_model[3]) begin
            miscompares++;
            $display("FAIL counters: got %0d %0d %0d %0d, expected %0d %0d %0d %0d",
                     cnt_v[0], cnt_v[1], cnt_v[2], cnt_v[3],
                     cnt_model[0], cnt_model[1], cnt_model[2], cnt_model[3]);
        end
        if (hold) begin
            vectors++;
            if (valid_out !== 1'b1 || data_out !== held) begin
                miscompares++;
                $display("FAIL hold: got valid=%b data=%h, expected valid=1 data=%h", valid_out, data_out, held);
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        full_out = 1'b0;
        clear_fifos();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic drain(input bit rand_full);
        int budget;
        budget = 600;
        while ((exp_q.size() > 0 || !idle) && budget > 0) begin
            full_out = rand_full ? ($urandom_range(0, 9) < 3) : 1'b0;
            step();
            budget--;
        end
        full_out = 1'b0;
        vectors++;
        if (exp_q.size() != 0 || idle !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d words outstanding, idle=%b, expected 0 and 1", exp_q.size(), idle);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        full_out = 1'b0;
        clear_fifos();
        load(0, 6'h15);
        repeat (2) begin
            @(posedge clk);
            #1;
            vectors++;
            if (pop_v !== 4'b0000 || valid_out !== 1'b0 || idle !== 1'b1 || sel !== 2'd0 ||
                cnt4 !== '0 || cnt5 !== '0 || cnt6 !== '0 || cnt7 !== '0) begin
                miscompares++;
                $display("FAIL reset_state: pop=%b valid=%b idle=%b sel=%0d cnt=%0d/%0d/%0d/%0d, expected 0000 0 1 0 0/0/0/0",
                         pop_v, valid_out, idle, sel, cnt4, cnt5, cnt6, cnt7);
            end
        end
        reset = 1'b0;
        build_expected();
        step();
        vectors++;
        if (pop_v !== 4'b0001 || sel !== 2'd0) begin
            miscompares++;
            $display("FAIL first_grant: pop=%b sel=%0d, expected 0001 0", pop_v, sel);
        end
        drain(1'b0);
    endtask

    task automatic test_single();
        logic [3:0] e_pop [5];
        logic       e_val [5];
        logic       e_idle [5];
        e_pop  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        e_val  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e_idle = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        load(1, 6'h2A);
        build_expected();
        for (int cyc = 0; cyc < 5; cyc++) begin
            vectors++;
            if (pop_v !== e_pop[cyc] || valid_out !== e_val[cyc] || idle !== e_idle[cyc]) begin
                miscompares++;
                $display("FAIL single_c%0d: pop=%b valid=%b idle=%b, expected %b %b %b",
                         cyc, pop_v, valid_out, idle, e_pop[cyc], e_val[cyc], e_idle[cyc]);
            end
            if (cyc == 3) begin
                vectors++;
                if (data_out !== 6'h2A || sel !== 2'd1) begin
                    miscompares++;
                    $display("FAIL single_data: data=%h sel=%0d, expected 2a 1", data_out, sel);
                end
            end
            if (cyc == 4) begin
                vectors++;
                if (cnt5 !== 8'd1) begin
                    miscompares++;
                    $display("FAIL single_cnt5: got %0d, expected 1", cnt5);
                end
            end
            if (cyc < 4) step();
        end
    endtask

    task automatic test_fairness();
        int order [$];
        apply_reset();
        for (int w = 0; w < 2; w++)
            for (int c = 0; c < 4; c++) load(c, 6'($urandom));
        build_expected();
        for (int cyc = 0; cyc < 32; cyc++) begin
            for (int c = 0; c < 4; c++)
                if (pop_v[c]) order.push_back(c);
            step();
        end
        vectors++;
        if (order.size() != 8) begin
            miscompares++;
            $display("FAIL fair_count: %0d grants, expected 8", order.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (order[i] != i % 4) begin
                    miscompares++;
                    $display("FAIL fair_order[%0d]: got %0d, expected %0d", i, order[i], i % 4);
                end
            end
        end
        vectors++;
        if (cnt4 !== 8'd2 || cnt5 !== 8'd2 || cnt6 !== 8'd2 || cnt7 !== 8'd2) begin
            miscompares++;
            $display("FAIL fair_cnt: got %0d %0d %0d %0d, expected 2 each", cnt4, cnt5, cnt6, cnt7);
        end
    endtask

    task automatic test_back_pressure();
        int                b;
        int                vcount;
        logic [DATA_W-1:0] held;
        apply_reset();
        load(2, 6'($urandom));
        build_expected();
        b = 10;
        while (!valid_out && b > 0) begin
            step();
            b--;
        end
        full_out = 1'b1;
        held = data_out;
        vcount = 0;
        repeat (5) begin
            if (valid_out) vcount++;
            step();
        end
        full_out = 1'b0;
        if (valid_out) vcount++;
        vectors++;
        if (vcount != 6 || data_out !== held || cnt6 !== 8'd0) begin
            miscompares++;
            $display("FAIL bp_hold: valid cycles=%0d data=%h cnt6=%0d, expected 6 %h 0", vcount, data_out, held, cnt6);
        end
        step();
        vectors++;
        if (cnt6 !== 8'd1 || valid_out !== 1'b0 || idle !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: cnt6=%0d valid=%b idle=%b, expected 1 0 1", cnt6, valid_out, idle);
        end
        full_out = 1'b1;
        load(3, 6'($urandom));
        build_expected();
        repeat (6) begin
            vectors++;
            if (pop_v !== 4'b0000 || idle !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_idle_block: pop=%b idle=%b, expected 0000 1", pop_v, idle);
            end
            step();
        end
        full_out = 1'b0;
        drain(1'b0);
    endtask

    task automatic test_reset_mid();
        int b;
        apply_reset();
        load(3, 6'($urandom));
        build_expected();
        b = 10;
        while (pop_v == 4'b0000 && b > 0) begin
            step();
            b--;
        end
        step();
        vectors++;
        if (idle !== 1'b0 || valid_out !== 1'b0 || pop_v !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_capt: idle=%b valid=%b pop=%b, expected 0 0 0000", idle, valid_out, pop_v);
        end
        reset = 1'b1;
        step();
        vectors++;
        if (idle !== 1'b1 || valid_out !== 1'b0 || cnt7 !== 8'd0 || pop_v !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset: idle=%b valid=%b cnt7=%0d pop=%b, expected 1 0 0 0000", idle, valid_out, cnt7, pop_v);
        end
        reset = 1'b0;
        repeat (4) step();
        vectors++;
        if (valid_out !== 1'b0 || idle !== 1'b1 || cnt7 !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_discard: valid=%b idle=%b cnt7=%0d, expected 0 1 0", valid_out, idle, cnt7);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            apply_reset();
            for (int c = 0; c < 4; c++) begin
                int n;
                n = $urandom_range(0, 4);
                for (int w = 0; w < n; w++) load(c, 6'($urandom));
            end
            build_expected();
            drain(1'b1);
        end
    endtask

    task automatic test_wrap();
        int rem;
        int delivered;
        reset_b = 1'b1;
        empty7_b = 1'b0;
        data7_b = 6'h11;
        rem = 5;
        delivered = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_b = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic pb;
            pb = pop7_b;
            if (valid_out_b) begin
                delivered++;
                vectors++;
                if (data_out_b !== 6'h11 || sel_b !== 2'd3) begin
                    miscompares++;
                    $display("FAIL wrap_data: data=%h sel=%0d, expected 11 3", data_out_b, sel_b);
                end
            end
            @(posedge clk);
            #1;
            if (pb) rem--;
            empty7_b = (rem == 0);
            vectors++;
            if (cnt7_b !== 2'(delivered % 4)) begin
                miscompares++;
                $display("FAIL wrap_cnt_c%0d: got %0d, expected %0d", cyc, cnt7_b, delivered % 4);
            end
        end
        vectors++;
        if (delivered != 5 || cnt7_b !== 2'd1) begin
            miscompares++;
            $display("FAIL wrap_final: delivered=%0d cnt7=%0d, expected 5 1", delivered, cnt7_b);
        end
        reset_b = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        reset_b = 1'b1;
        full_out = 1'b0;
        empty7_b = 1'b1;
        data7_b = 6'h00;
        clear_fifos();
        test_reset();
        test_single();
        test_fairness();
        test_back_pressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
